// File: rtl/alu_pkg.sv
// Shared constants for the accumulator ALU: FSM state encodings, one-hot
// operation selects and operand-mux select bits.
package alu_pkg;

  localparam int unsigned WIDTH = 8;

  localparam logic [1:0] OFF  = 2'b00;
  localparam logic [1:0] IDLE = 2'b01;
  localparam logic [1:0] RUN  = 2'b10;
  localparam logic [1:0] ERR  = 2'b11;

  localparam logic [6:0] OP_ADD = 7'b1000000;
  localparam logic [6:0] OP_SUB = 7'b0100000;
  localparam logic [6:0] OP_MUL = 7'b0010000;
  localparam logic [6:0] OP_AND = 7'b0001000;
  localparam logic [6:0] OP_OR  = 7'b0000100;
  localparam logic [6:0] OP_XOR = 7'b0000010;
  localparam logic [6:0] OP_NOT = 7'b0000001;

  localparam int unsigned PERSIST = 2;
  localparam int unsigned LOAD    = 1;
  localparam int unsigned RESET   = 0;

  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == SEL_PERSIST) || (v == SEL_LOAD) || (v == SEL_RESET);
  endfunction

  function automatic logic is_onehot7(input logic [6:0] v);
    return (v != '0) && ((v & (v - 7'd1)) == '0);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational operation unit: applies the one-hot selected op to (a, b).
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [6:0]       out_sel,
  output logic [WIDTH-1:0] result
);

  // All ops wrap at WIDTH bits; non-one-hot selects yield 0 (never stored).
  always_comb begin
    result = '0;
    unique case (out_sel)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/main.sv
// Accumulator ALU top: operand muxes, B/out registers and the 2-bit control FSM.
// Exports current and next state for debug.
module main
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [6:0]       out_sel,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       currState,
  output logic [1:0]       nextState
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] a_n, b_n, result;
  logic             valid;

  assign valid = is_onehot3(in_sel) && is_onehot7(out_sel);

  always_comb begin
    state_d = state_q;
    if (!rst || !on) begin
      state_d = OFF;
    end else begin
      unique case (state_q)
        OFF:     state_d = IDLE;
        IDLE:    state_d = valid ? RUN : ERR;
        RUN:     state_d = valid ? RUN : ERR;
        ERR:     state_d = valid ? IDLE : ERR;
        default: state_d = OFF;
      endcase
    end
  end

  // A is never held across cycles: its next value always comes from out,
  // num1 or zero, so only A_n is materialised.
  always_comb begin
    a_n = '0;
    b_n = '0;
    unique case (in_sel)
      SEL_PERSIST: begin
        a_n = out_q;
        b_n = b_q;
      end
      SEL_LOAD: begin
        a_n = num1;
        b_n = num2;
      end
      SEL_RESET: begin
        a_n = '0;
        b_n = '0;
      end
      default: begin
        a_n = out_q;
        b_n = b_q;
      end
    endcase
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a       (a_n),
    .b       (b_n),
    .out_sel (out_sel),
    .result  (result)
  );

  always_comb begin
    b_d   = b_q;
    out_d = out_q;
    if (state_d == RUN) begin
      b_d   = b_n;
      out_d = result;
    end else if (state_d == OFF) begin
      b_d   = '0;
      out_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= OFF;
      b_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      out_q   <= out_d;
    end
  end

  assign out       = out_q;
  assign currState = state_q;
  assign nextState = state_d;

endmodule

// File: tb/tb_main.sv
// Self-checking bench for main: directed scenarios plus randomized stimulus
// compared against a behavioural model of the ALU.
module tb_main;

  logic       clk;
  logic       rst;
  logic       on;
  logic [2:0] in_sel;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [6:0] out_sel;
  logic [7:0] out;
  logic [1:0] currState;
  logic [1:0] nextState;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Behavioural model state.
  int unsigned m_state = 0;
  int unsigned m_b     = 0;
  int unsigned m_out   = 0;

  main #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .on        (on),
    .in_sel    (in_sel),
    .num1      (num1),
    .num2      (num2),
    .out_sel   (out_sel),
    .out       (out),
    .currState (currState),
    .nextState (nextState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_op(input int unsigned a, input int unsigned b,
                                         input logic [6:0] sel);
    case (sel)
      7'b1000000: return (a + b) % 256;
      7'b0100000: return (a + 256 - b) % 256;
      7'b0010000: return (a * b) % 256;
      7'b0001000: return a & b;
      7'b0000100: return a | b;
      7'b0000010: return a ^ b;
      7'b0000001: return 255 - a;
      default:    return 0;
    endcase
  endfunction

  task automatic step(input logic r, input logic o, input logic [2:0] is,
                      input logic [6:0] os, input logic [7:0] n1, input logic [7:0] n2);
    int unsigned nxt, an, bn;
    bit          ok;
    rst = r; on = o; in_sel = is; out_sel = os; num1 = n1; num2 = n2;
    ok = ($countones(is) == 1) && ($countones(os) == 1);
    if (!r || !o)          nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 3) nxt = ok ? 1 : 3;
    else                   nxt = ok ? 2 : 3;
    #1;
    check("next_state", {30'd0, nextState}, nxt);
    @(posedge clk);
    #1;
    if (nxt == 2) begin
      an = (is == 3'b100) ? m_out : (is == 3'b010) ? n1 : 0;
      bn = (is == 3'b100) ? m_b   : (is == 3'b010) ? n2 : 0;
      m_out = ref_op(an, bn, os);
      m_b   = bn;
    end else if (nxt == 0) begin
      m_out = 0;
      m_b   = 0;
    end
    m_state = nxt;
    check("curr_state", {30'd0, currState}, m_state);
    check("out", {24'd0, out}, m_out);
  endtask

  function automatic logic [2:0] rand_in_sel();
    logic [2:0] v;
    if ($urandom_range(7, 0) == 0) v = 3'($urandom_range(7, 0));
    else                           v = 3'(1 << $urandom_range(2, 0));
    return v;
  endfunction

  function automatic logic [6:0] rand_out_sel();
    logic [6:0] v;
    if ($urandom_range(7, 0) == 0) v = 7'($urandom_range(127, 0));
    else                           v = 7'(1 << $urandom_range(6, 0));
    return v;
  endfunction

  logic [6:0] ops [7];
  int unsigned op_exp [7];

  initial begin
    ops    = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000,
               7'b0000100, 7'b0000010, 7'b0000001};
    op_exp = '{113, 61, 214, 18, 95, 77, 168};

    rst = 1'b0; on = 1'b0; in_sel = '0; out_sel = '0; num1 = '0; num2 = '0;
    @(negedge clk);

    // Reset, then power on.
    step(1'b0, 1'b0, 3'b010, 7'b1000000, 8'd87, 8'd26);
    check("reset_state", {30'd0, currState}, 0);
    check("reset_out", {24'd0, out}, 0);
    step(1'b1, 1'b1, 3'b010, 7'b1000000, 8'd87, 8'd26);
    check("power_on_idle", {30'd0, currState}, 1);

    // Each op on loaded operands.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 3'b010, ops[i], 8'd87, 8'd26);
      check($sformatf("op%0d", i), {24'd0, out}, op_exp[i]);
    end

    // Accumulate with wrap.
    step(1'b1, 1'b1, 3'b010, 7'b1000000, 8'd87, 8'd26);
    check("acc_load", {24'd0, out}, 113);
    step(1'b1, 1'b1, 3'b100, 7'b1000000, 8'd0, 8'd0);
    check("acc_1", {24'd0, out}, 139);
    step(1'b1, 1'b1, 3'b100, 7'b1000000, 8'd0, 8'd0);
    check("acc_2", {24'd0, out}, 165);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'b100, 7'b1000000, 8'd0, 8'd0);
    check("acc_wrap", {24'd0, out}, 13);

    // Invalid selects hold out and go to ERR, then recover.
    step(1'b1, 1'b1, 3'b010, 7'b0000011, 8'd1, 8'd2);
    check("err_bad_op", {30'd0, currState}, 3);
    check("err_hold", {24'd0, out}, 13);
    step(1'b1, 1'b1, 3'b010, 7'b1000000, 8'd1, 8'd2);
    check("err_to_idle", {30'd0, currState}, 1);
    step(1'b1, 1'b1, 3'b010, 7'b1000000, 8'd1, 8'd2);
    check("idle_to_run", {24'd0, out}, 3);
    step(1'b1, 1'b1, 3'b011, 7'b1000000, 8'd9, 8'd9);
    check("err_bad_in", {30'd0, currState}, 3);
    check("err_hold2", {24'd0, out}, 3);
    step(1'b1, 1'b1, 3'b010, 7'b1000000, 8'd5, 8'd6);
    step(1'b1, 1'b1, 3'b010, 7'b1000000, 8'd5, 8'd6);
    check("run_again", {24'd0, out}, 11);

    // Power off mid-run, then reset priority over on.
    step(1'b1, 1'b0, 3'b010, 7'b1000000, 8'd5, 8'd6);
    check("off_state", {30'd0, currState}, 0);
    check("off_out", {24'd0, out}, 0);
    step(1'b1, 1'b1, 3'b010, 7'b1000000, 8'd5, 8'd6);
    step(1'b0, 1'b1, 3'b010, 7'b1000000, 8'd5, 8'd6);
    check("rst_over_on", {30'd0, currState}, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(31, 0) != 0), ($urandom_range(15, 0) != 0), rand_in_sel(),
           rand_out_sel(), 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
